ov7670_rgb444_tx: RTL

Camera-side source for the OV7670 RGB444 byte interface. It accepts 12-bit RGB444 pixels over a valid/ready handshake and serialises them into the OV7670 output format: one byte per PCLK, with byte 0 = {4'h0, R} and byte 1 = {G, B}. It also generates the HREF and VSYNC framing. It drives the RGB444 deserialiser in simulation and serves as a pattern source on hardware when no sensor is fitted.

---
 rtl/ov7670_rgb444_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ov7670_rgb444_tx.sv
// OV7670-style RGB444 byte source: takes 12-bit pixels over valid/ready and
// emits {4'h0,R} then {G,B} per pixel with HREF/VSYNC framing.
module ov7670_rgb444_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        PCLK,
  input  logic        RST,
  input  logic        i_enable,
  input  logic [11:0] i_RGB_444,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_byte,
  output logic        HREF,
  output logic        VSYNC,
  output logic        o_frame_done,
  output logic        o_underflow
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int BW    = $clog2(LINE);
  localparam int VM_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX  = (VM_A > VM_B) ? VM_A : VM_B;
  localparam int LW    = $clog2(VMAX + 1);

  localparam logic [BW-1:0] LINE_END = BW'(LINE - 1);
  localparam logic [BW-1:0] ACT_END  = BW'(2 * H_ACTIVE - 1);
  localparam logic [BW-1:0] HB_END   = BW'(H_BLANK - 1);
  localparam logic [LW-1:0] VS_END   = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_END   = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VA_END   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VF_END   = LW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_BYTE0, S_BYTE1, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [LW-1:0] line_cnt_reg, line_cnt_next;
  logic [11:0]   pixel_reg;
  logic [11:0]   in_pixel;
  logic          ready_next, href_next, vsync_next, done_next;
  logic [7:0]    byte_out_next;

  // A missing pixel is replaced by black so timing never stalls
  assign in_pixel = i_valid ? i_RGB_444 : 12'h000;

  // State and counter registers
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= '0;
      line_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      line_cnt_reg <= line_cnt_next;
    end
  end

  // Next-state and counter logic; the byte counter spans a whole active line
  // across BYTE0/BYTE1 and restarts at every line/blank boundary
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg + 1'b1;
    line_cnt_next = line_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        byte_cnt_next = '0;
        if (i_enable) state_next = S_VSYNC;
      end
      S_VSYNC: begin
        if (byte_cnt_reg == LINE_END) begin
          byte_cnt_next = '0;
          if (line_cnt_reg == VS_END) begin
            state_next    = S_VBACK;
            line_cnt_next = '0;
          end else begin
            line_cnt_next = line_cnt_reg + 1'b1;
          end
        end
      end
      S_VBACK: begin
        if (byte_cnt_reg == LINE_END) begin
          byte_cnt_next = '0;
          if (line_cnt_reg == VB_END) begin
            state_next    = S_BYTE0;
            line_cnt_next = '0;
          end else begin
            line_cnt_next = line_cnt_reg + 1'b1;
          end
        end
      end
      S_BYTE0: state_next = S_BYTE1;
      S_BYTE1: begin
        if (byte_cnt_reg == ACT_END) begin
          state_next    = S_HBLANK;
          byte_cnt_next = '0;
        end else begin
          state_next = S_BYTE0;
        end
      end
      S_HBLANK: begin
        if (byte_cnt_reg == HB_END) begin
          byte_cnt_next = '0;
          if (line_cnt_reg == VA_END) begin
            state_next    = S_VFRONT;
            line_cnt_next = '0;
          end else begin
            state_next    = S_BYTE0;
            line_cnt_next = line_cnt_reg + 1'b1;
          end
        end
      end
      S_VFRONT: begin
        if (byte_cnt_reg == LINE_END && line_cnt_reg == VF_END) begin
          byte_cnt_next = '0;
          line_cnt_next = '0;
          state_next    = i_enable ? S_VSYNC : S_IDLE;
        end else if (byte_cnt_reg == LINE_END) begin
          byte_cnt_next = '0;
          line_cnt_next = line_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = S_IDLE;
        byte_cnt_next = '0;
        line_cnt_next = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop;
  // ready looks one cycle further ahead to flag the cycle before BYTE0
  always_comb begin
    href_next  = (state_next == S_BYTE0) || (state_next == S_BYTE1);
    vsync_next = (state_next == S_VSYNC);
    done_next  = (state_next == S_VFRONT) && (line_cnt_next == VF_END) &&
                 (byte_cnt_next == LINE_END);
    ready_next = ((state_next == S_VBACK) && (byte_cnt_next == LINE_END) &&
                  (line_cnt_next == VB_END)) ||
                 ((state_next == S_BYTE1) && (byte_cnt_next != ACT_END)) ||
                 ((state_next == S_HBLANK) && (byte_cnt_next == HB_END) &&
                  (line_cnt_next != VA_END));
    case (state_next)
      S_BYTE0: byte_out_next = {4'h0, in_pixel[11:8]};
      S_BYTE1: byte_out_next = pixel_reg[7:0];
      default: byte_out_next = 8'h00;
    endcase
  end

  // Registered outputs
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      o_ready      <= 1'b0;
      o_byte       <= 8'h00;
      HREF         <= 1'b0;
      VSYNC        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_ready      <= ready_next;
      o_byte       <= byte_out_next;
      HREF         <= href_next;
      VSYNC        <= vsync_next;
      o_frame_done <= done_next;
    end
  end

  // Pixel latch on the handshake edge, with sticky underflow on a missing pixel
  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      pixel_reg   <= 12'h000;
      o_underflow <= 1'b0;
    end else if (o_ready) begin
      pixel_reg <= in_pixel;
      if (!i_valid) o_underflow <= 1'b1;
    end
  end

endmodule
